// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush/freeze controller for a 5-stage in-order pipeline without forwarding.
// The enables and flushes are combinational. The state, the performance counters and the watchdog are registered.

module hazard_src_match (
  input  logic            [4:0] rs_addr,
  input  logic                  rs_used,
  input  logic [2:0]      [4:0] rd_addr,
  input  logic [2:0]            reg_write,
  output logic                  match
);
  logic [2:0] hit;

  genvar s;
  generate
    for (s = 0; s < 3; s++) begin : g_stage
      assign hit[s] = reg_write[s] && (rd_addr[s] == rs_addr);
    end
  endgenerate

  // x0 is hardwired to zero, so a "write" to it never creates a dependency.
  assign match = rs_used && (rs_addr != 5'd0) && (|hit);
endmodule

module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_addr_ID,
  input  logic [4:0]       Rs2_addr_ID,
  input  logic             Rs1_used_ID,
  input  logic             Rs2_used_ID,
  input  logic [4:0]       Rd_addr_EX,
  input  logic [4:0]       Rd_addr_Mem,
  input  logic [4:0]       Rd_addr_WB,
  input  logic             RegWrite_EX,
  input  logic             RegWrite_Mem,
  input  logic             RegWrite_WB,
  input  logic             PCSrc,
  input  logic             MIO_ready,
  output logic             en_IF,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXMem,
  output logic             en_MemWB,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             flush_EXMem,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             hazard_err
);
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    FLUSH  = 2'b10,
    FREEZE = 2'b11
  } cls_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cls_t state, state_nxt;
  logic [1:0] src_match;
  logic       hazard;
  logic [1:0] consec;

  logic [2:0][4:0] rd_addr;
  logic [2:0]      reg_write;
  logic [1:0][4:0] rs_addr;
  logic [1:0]      rs_used;

  assign rd_addr   = {Rd_addr_WB, Rd_addr_Mem, Rd_addr_EX};
  assign reg_write = {RegWrite_WB, RegWrite_Mem, RegWrite_EX};
  assign rs_addr   = {Rs2_addr_ID, Rs1_addr_ID};
  assign rs_used   = {Rs2_used_ID, Rs1_used_ID};

  genvar r;
  generate
    for (r = 0; r < 2; r++) begin : g_src
      hazard_src_match u_match (
        .rs_addr   (rs_addr[r]),
        .rs_used   (rs_used[r]),
        .rd_addr   (rd_addr),
        .reg_write (reg_write),
        .match     (src_match[r])
      );
    end
  endgenerate

  assign hazard = |src_match;

  // The state register holds the class of the previous cycle.
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = RUN;
    en_IF       = 1'b1;
    en_IFID     = 1'b1;
    en_IDEX     = 1'b1;
    en_EXMem    = 1'b1;
    en_MemWB    = 1'b1;
    flush_IFID  = 1'b0;
    flush_IDEX  = 1'b0;
    flush_EXMem = 1'b0;
    if (!MIO_ready)   state_nxt = FREEZE;
    else if (PCSrc)   state_nxt = FLUSH;
    else if (hazard)  state_nxt = STALL;
    // While the block is in reset, leave every pipeline register free to apply its own reset.
    if (rst) begin
      case (state_nxt)
        FREEZE: begin
          en_IF    = 1'b0;
          en_IFID  = 1'b0;
          en_IDEX  = 1'b0;
          en_EXMem = 1'b0;
          en_MemWB = 1'b0;
        end
        FLUSH: begin
          flush_IFID  = 1'b1;
          flush_IDEX  = 1'b1;
          flush_EXMem = 1'b1;
        end
        STALL: begin
          en_IF      = 1'b0;
          en_IFID    = 1'b0;
          flush_IDEX = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_out = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (state_nxt == STALL  && stall_cnt  != CNT_MAX) stall_cnt  <= stall_cnt  + 1'b1;
      if (state_nxt == FLUSH  && flush_cnt  != CNT_MAX) flush_cnt  <= flush_cnt  + 1'b1;
      if (state_nxt == FREEZE && freeze_cnt != CNT_MAX) freeze_cnt <= freeze_cnt + 1'b1;
    end
  end

  // A freeze pauses the stall run rather than ending it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      consec     <= 2'd0;
      hazard_err <= 1'b0;
    end else begin
      case (state_nxt)
        STALL: begin
          if (consec != 2'd3) consec <= consec + 2'd1;
          else                hazard_err <= 1'b1;
        end
        RUN, FLUSH: consec <= 2'd0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. The expected values are worked out by hand from the cycle-class rules.

module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1_addr_ID, Rs2_addr_ID, Rd_addr_EX, Rd_addr_Mem, Rd_addr_WB;
  logic Rs1_used_ID, Rs2_used_ID, RegWrite_EX, RegWrite_Mem, RegWrite_WB;
  logic PCSrc, MIO_ready;
  logic en_IF, en_IFID, en_IDEX, en_EXMem, en_MemWB;
  logic flush_IFID, flush_IDEX, flush_EXMem;
  logic [1:0] state_out;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
  logic hazard_err;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1_addr_ID(Rs1_addr_ID), .Rs2_addr_ID(Rs2_addr_ID),
    .Rs1_used_ID(Rs1_used_ID), .Rs2_used_ID(Rs2_used_ID),
    .Rd_addr_EX(Rd_addr_EX), .Rd_addr_Mem(Rd_addr_Mem), .Rd_addr_WB(Rd_addr_WB),
    .RegWrite_EX(RegWrite_EX), .RegWrite_Mem(RegWrite_Mem), .RegWrite_WB(RegWrite_WB),
    .PCSrc(PCSrc), .MIO_ready(MIO_ready),
    .en_IF(en_IF), .en_IFID(en_IFID), .en_IDEX(en_IDEX), .en_EXMem(en_EXMem), .en_MemWB(en_MemWB),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .flush_EXMem(flush_EXMem),
    .state_out(state_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .freeze_cnt(freeze_cnt), .hazard_err(hazard_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b1;
    Rs1_addr_ID = 5'd0; Rs2_addr_ID = 5'd0; Rs1_used_ID = 1'b0; Rs2_used_ID = 1'b0;
    Rd_addr_EX = 5'd0; Rd_addr_Mem = 5'd0; Rd_addr_WB = 5'd0;
    RegWrite_EX = 1'b0; RegWrite_Mem = 1'b0; RegWrite_WB = 1'b0;
    PCSrc = 1'b0; MIO_ready = 1'b1;
  endtask

  task automatic set_hazard();
    Rs1_addr_ID = 5'd5; Rs1_used_ID = 1'b1; Rd_addr_EX = 5'd5; RegWrite_EX = 1'b1;
  endtask

  function automatic logic [7:0] ctl();
    return {en_IF, en_IFID, en_IDEX, en_EXMem, en_MemWB, flush_IFID, flush_IDEX, flush_EXMem};
  endfunction

  localparam logic [7:0] CTL_RUN    = 8'b11111_000;
  localparam logic [7:0] CTL_STALL  = 8'b00111_010;
  localparam logic [7:0] CTL_FLUSH  = 8'b11111_111;
  localparam logic [7:0] CTL_FREEZE = 8'b00000_000;

  task automatic test_reset();
    idle();
    set_hazard();
    rst = 1'b0; PCSrc = 1'b1; MIO_ready = 1'b0;
    #1;
    checks++;
    if (ctl() !== CTL_RUN) begin
      errors++; $display("FAIL reset_ctl got %b want %b", ctl(), CTL_RUN);
    end
    tick();
    checks++;
    if ({state_out, stall_cnt, flush_cnt, freeze_cnt, hazard_err} !== '0) begin
      errors++;
      $display("FAIL reset_regs got st=%b s=%0d f=%0d z=%0d e=%b want all 0",
               state_out, stall_cnt, flush_cnt, freeze_cnt, hazard_err);
    end
    idle();
  endtask

  task automatic test_stall();
    set_hazard();
    #1;
    checks++;
    if (ctl() !== CTL_STALL) begin
      errors++; $display("FAIL stall_ctl got %b want %b", ctl(), CTL_STALL);
    end
    tick();
    checks++;
    if (state_out !== 2'b01 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL stall_regs got st=%b s=%0d want st=01 s=1", state_out, stall_cnt);
    end
    idle();
  endtask

  task automatic test_no_hazard();
    Rs2_addr_ID = 5'd0; Rs2_used_ID = 1'b1; Rd_addr_Mem = 5'd0; RegWrite_Mem = 1'b1;
    #1;
    checks++;
    if (ctl() !== CTL_RUN) begin
      errors++; $display("FAIL x0_ctl got %b want %b", ctl(), CTL_RUN);
    end
    tick();
    idle();
    set_hazard();
    Rs1_used_ID = 1'b0;
    #1;
    checks++;
    if (ctl() !== CTL_RUN) begin
      errors++; $display("FAIL unused_ctl got %b want %b", ctl(), CTL_RUN);
    end
    tick();
    checks++;
    if (state_out !== 2'b00 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL nohaz_regs got st=%b s=%0d want st=00 s=1", state_out, stall_cnt);
    end
    idle();
    // A WB-stage match on rs2 is still a hazard.
    Rs2_addr_ID = 5'd9; Rs2_used_ID = 1'b1; Rd_addr_WB = 5'd9; RegWrite_WB = 1'b1;
    #1;
    checks++;
    if (ctl() !== CTL_STALL) begin
      errors++; $display("FAIL wb_match_ctl got %b want %b", ctl(), CTL_STALL);
    end
    idle();
  endtask

  task automatic test_flush();
    set_hazard();
    PCSrc = 1'b1;
    #1;
    checks++;
    if (ctl() !== CTL_FLUSH) begin
      errors++; $display("FAIL flush_ctl got %b want %b", ctl(), CTL_FLUSH);
    end
    tick();
    checks++;
    if (state_out !== 2'b10 || flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL flush_regs got st=%b f=%0d s=%0d want st=10 f=1 s=1",
                         state_out, flush_cnt, stall_cnt);
    end
    idle();
  endtask

  task automatic test_freeze();
    PCSrc = 1'b1; MIO_ready = 1'b0;
    set_hazard();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl() !== CTL_FREEZE) begin
        errors++; $display("FAIL freeze_ctl[%0d] got %b want %b", i, ctl(), CTL_FREEZE);
      end
      tick();
    end
    checks++;
    if (state_out !== 2'b11 || freeze_cnt !== 16'd4 || flush_cnt !== 16'd1) begin
      errors++; $display("FAIL freeze_regs got st=%b z=%0d f=%0d want st=11 z=4 f=1",
                         state_out, freeze_cnt, flush_cnt);
    end
    MIO_ready = 1'b1;
    #1;
    checks++;
    if (ctl() !== CTL_FLUSH) begin
      errors++; $display("FAIL unfreeze_ctl got %b want %b", ctl(), CTL_FLUSH);
    end
    tick();
    checks++;
    if (flush_cnt !== 16'd2 || state_out !== 2'b10) begin
      errors++; $display("FAIL unfreeze_regs got f=%0d st=%b want f=2 st=10", flush_cnt, state_out);
    end
    idle();
  endtask

  task automatic test_watchdog();
    set_hazard();
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (hazard_err !== (i >= 4)) begin
        errors++; $display("FAIL wdog_edge%0d got %b want %b", i, hazard_err, (i >= 4));
      end
    end
    checks++;
    if (stall_cnt !== 16'd6) begin
      errors++; $display("FAIL wdog_stallcnt got %0d want 6", stall_cnt);
    end
    idle();
    tick();
    checks++;
    if (hazard_err !== 1'b1) begin
      errors++; $display("FAIL wdog_sticky got %b want 1", hazard_err);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (hazard_err !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL wdog_clear got e=%b s=%0d f=%0d want 0 0 0", hazard_err, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_freeze_keeps_run();
    // Sequence stall, stall, freeze, stall, stall: the freeze must not reset the run length.
    set_hazard();
    tick(); tick();
    MIO_ready = 1'b0; tick();
    MIO_ready = 1'b1; tick();
    checks++;
    if (hazard_err !== 1'b0) begin
      errors++; $display("FAIL frz_run3 got %b want 0", hazard_err);
    end
    tick();
    checks++;
    if (hazard_err !== 1'b1 || stall_cnt !== 16'd4 || freeze_cnt !== 16'd1) begin
      errors++; $display("FAIL frz_run4 got e=%b s=%0d z=%0d want e=1 s=4 z=1",
                         hazard_err, stall_cnt, freeze_cnt);
    end
    // A reset in the middle of a freeze wins over it and clears the counts.
    MIO_ready = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if (ctl() !== CTL_RUN) begin
      errors++; $display("FAIL rst_frz_ctl got %b want %b", ctl(), CTL_RUN);
    end
    tick();
    checks++;
    if (state_out !== 2'b00 || freeze_cnt !== 16'd0 || hazard_err !== 1'b0) begin
      errors++; $display("FAIL rst_frz_regs got st=%b z=%0d e=%b want 00 0 0", state_out, freeze_cnt, hazard_err);
    end
    idle();
  endtask

  task automatic test_saturation();
    set_hazard();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== {CNT_W{1'b1}} || state_out !== 2'b01) begin
      errors++; $display("FAIL stall_sat got s=%h st=%b want s=ffff st=01", stall_cnt, state_out);
    end
    idle();
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_stall();
    test_no_hazard();
    test_flush();
    test_freeze();
    test_watchdog();
    test_freeze_keeps_run();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
